// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared execute-stage constants and divider state encoding
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_BUSY = S_BUSY,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - start/ready/done handshake and operand/result bundle
interface seq_divider_if import seq_divider_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic             d_signed;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             ready;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, d_signed, src_a, src_b,
    input  ready, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, d_signed, src_a, src_b,
    output ready, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring division step on magnitudes
module seq_divider_div_step import seq_divider_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    borrow   = shifted < {2'b00, divisor};
    trial    = shifted[WIDTH:0] - {1'b0, divisor};
    rem_next = borrow ? shifted[WIDTH:0] : trial;
    quo_next = {quo[WIDTH-2:0], ~borrow};
  end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider for div/divu, one quotient bit per clock
module seq_divider import seq_divider_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [WIDTH:0]   rem_q, rem_step;
  logic [WIDTH-1:0] quo_q, quo_step, divisor_q;
  logic [CW-1:0]    counter;
  logic             sign_q, sign_r;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             dbz_q;

  logic             accept, zero_div, a_neg, b_neg, last_step;
  logic [WIDTH-1:0] mag_a, mag_b, quo_fixed, rem_fixed;

  always_comb begin
    accept    = bus.start && (state != ST_BUSY);
    zero_div  = (bus.src_b == '0);
    a_neg     = bus.d_signed && bus.src_a[WIDTH-1];
    b_neg     = bus.d_signed && bus.src_b[WIDTH-1];
    mag_a     = a_neg ? (~bus.src_a + WIDTH'(1)) : bus.src_a;
    mag_b     = b_neg ? (~bus.src_b + WIDTH'(1)) : bus.src_b;
    last_step = (state == ST_BUSY) && (counter == '0);
    // Sign fix-up on the final step so results register at the same edge
    quo_fixed = sign_q ? (~quo_step + WIDTH'(1)) : quo_step;
    rem_fixed = sign_r ? (~rem_step[WIDTH-1:0] + WIDTH'(1)) : rem_step[WIDTH-1:0];
  end

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (divisor_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.ready  = 1'b1;
    bus.done   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = zero_div ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        bus.ready = 1'b0;
        if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        bus.done   = 1'b1;
        state_next = accept ? (zero_div ? ST_DONE : ST_BUSY) : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      counter     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      if (zero_div) begin
        quotient_q  <= '1;
        remainder_q <= bus.src_a;
        dbz_q       <= 1'b1;
      end else begin
        rem_q     <= '0;
        quo_q     <= mag_a;
        divisor_q <= mag_b;
        counter   <= CW'(WIDTH - 1);
        sign_q    <= a_neg ^ b_neg;
        sign_r    <= a_neg;
        dbz_q     <= 1'b0;
      end
    end else if (state == ST_BUSY) begin
      rem_q   <= rem_step;
      quo_q   <= quo_step;
      counter <= counter - CW'(1);
      if (last_step) begin
        quotient_q  <= quo_fixed;
        remainder_q <= rem_fixed;
      end
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed vectors and handshake corner cases for seq_divider
module tb_seq_divider;
  localparam int W = 32;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input vec_t v);
    bus.start    = 1'b1;
    bus.d_signed = v.sgn;
    bus.src_a    = v.a;
    bus.src_b    = v.b;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic finish(input vec_t v, input string name, input int lat0);
    int   lat;
    logic busy_ok;
    lat     = lat0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (bus.ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 32'(lat), (v.b == 0) ? 32'd0 : 32'(W));
    check({name, "_q"}, bus.quotient, v.q);
    check({name, "_r"}, bus.remainder, v.r);
    check({name, "_dz"}, {31'd0, bus.div_by_zero}, {31'd0, v.dz});
    if (v.b != 0) check({name, "_busy_ready"}, {31'd0, busy_ok}, 32'd1);
  endtask

  vec_t vecs[11];
  vec_t va, vb, vc;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[6]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
    vecs[7]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,   32'd16,         32'h0FFFFFFF,   32'd15,         1'b0};
    vecs[10] = '{1'b0, 32'd3,          32'd7,          32'd0,          32'd3,          1'b0};

    bus.start = 1'b0; bus.d_signed = 1'b0; bus.src_a = '0; bus.src_b = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dz", {31'd0, bus.div_by_zero}, 32'd0);
    check("rst_q", bus.quotient, 32'd0);
    check("rst_r", bus.remainder, 32'd0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      launch(vecs[i]);
      finish(vecs[i], $sformatf("v%0d", i), 0);
      @(posedge clk); #1;
    end

    // start during BUSY with different operands must be ignored
    va = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    @(negedge clk);
    launch(va);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.d_signed = 1'b1; bus.src_a = 32'd50; bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finish(va, "busy_start", 6);
    @(posedge clk); #1;

    // start in the DONE cycle: next op begins with no idle gap
    vb = '{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0};
    @(negedge clk);
    launch(vb);
    finish(vb, "b2b_first", 0);
    launch(va);
    check("b2b_busy_now", {31'd0, bus.ready}, 32'd0);
    finish(va, "b2b_second", 0);
    @(posedge clk); #1;

    // reset at edge 10 abandons the operation
    vc = '{1'b1, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0};
    @(negedge clk);
    launch(vc);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_ready", {31'd0, bus.ready}, 32'd1);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_q", bus.quotient, 32'd0);
    check("midrst_r", bus.remainder, 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (bus.done) seen = 1'b1;
      end
      check("midrst_no_done", {31'd0, seen}, 32'd0);
    end
    @(negedge clk);
    launch(vb);
    finish(vb, "after_rst", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
